// File: rtl/mitll_merge_sched.sv
// Pulse-merge scheduler: counts toggle-encoded pulses per requester and re-emits them
// round-robin on one toggle output, at least MIN_GAP+1 cycles apart.
module mitll_merge_sched #(
  parameter int  N_REQ      = 2,
  parameter int  CNT_W      = 3,
  parameter int  MIN_GAP    = 2,
  parameter real CLK_TO_OUT = 4.0,
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             out,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] overflow
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  // CLK_TO_OUT is a timing annotation for the clk->out path; the RTL toggles on the edge.
  if (N_REQ < 2 || CNT_W < 1 || MIN_GAP < 0 || CLK_TO_OUT < 0.0) begin : g_bad_param
    $error("mitll_merge_sched: illegal parameter set");
  end

  logic [0:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDW-1:0]   rr_ptr;
  logic [N_REQ-1:0] req_prev;
  logic [CNT_W-1:0] cnt [N_REQ];

  logic             pick_vld;
  logic [IDW-1:0]   pick_idx;
  logic             grant;
  logic             any_pend;

  // Round-robin scan over registered counts, starting at rr_ptr.
  always_comb begin : rr_pick
    int unsigned cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % N_REQ;
      if (!pick_vld && cnt[cand[IDW-1:0]] != '0) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    any_pend = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (cnt[i] != '0) any_pend = 1'b1;
    end
  end

  assign grant = (state == ST_IDLE) && pick_vld;
  assign busy  = (state != ST_IDLE) || any_pend;

  // Arrival and grant on the same edge cancel, so a full counter absorbs that pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev <= '0;
      overflow <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      req_prev <= req;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if ((req[i] ^ req_prev[i]) && !(grant && pick_idx == IDW'(i))) begin
          if (cnt[i] == CNT_MAX) overflow[i] <= 1'b1;
          else                   cnt[i]      <= cnt[i] + 1'b1;
        end else if (!(req[i] ^ req_prev[i]) && grant && pick_idx == IDW'(i)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      rr_ptr   <= '0;
      out      <= 1'b0;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            out      <= ~out;
            grant_id <= pick_idx;
            rr_ptr   <= (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
            if (MIN_GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(MIN_GAP);
            end
          end
        end
        default: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mitll_merge_sched.sv
// Bench for mitll_merge_sched: directed scenarios plus random toggling, every cycle
// compared against a timeline model of pending counts, rotation and output spacing.
module tb_mitll_merge_sched;

  localparam int N_REQ   = 2;
  localparam int CNT_W   = 3;
  localparam int MIN_GAP = 2;
  localparam int IDW     = 1;
  localparam int PMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             out;
  logic [IDW-1:0]   grant_id;
  logic             busy;
  logic [N_REQ-1:0] overflow;

  mitll_merge_sched #(
    .N_REQ(N_REQ), .CNT_W(CNT_W), .MIN_GAP(MIN_GAP), .CLK_TO_OUT(4.0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out(out),
    .grant_id(grant_id), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: pending counts, rotation pointer, earliest cycle a grant may occur
  int               m_pend [N_REQ];
  int               m_rr;
  int               next_ok;
  int               cyc;
  logic             m_out;
  int               m_gid;
  logic [N_REQ-1:0] m_ovf;
  logic [N_REQ-1:0] m_prev;
  logic [N_REQ-1:0] cur;
  int               m_tog;

  logic             obs_out_prev;
  int               dut_tog;
  int               tog_cyc [$];
  int               tog_gid [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_REQ; i++) m_pend[i] = 0;
    m_rr = 0; next_ok = cyc; m_out = 1'b0; m_gid = 0;
    m_ovf = '0; m_prev = '0; cur = '0;
    obs_out_prev = 1'b0;
  endtask

  task automatic step(input logic [N_REQ-1:0] r);
    bit gnt;
    int gidx;
    bit pend_any;
    @(negedge clk);
    req = r;
    @(posedge clk);
    gnt = 0; gidx = 0;
    if (cyc >= next_ok) begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = (m_rr + k) % N_REQ;
        if (!gnt && m_pend[c] > 0) begin gnt = 1; gidx = c; end
      end
    end
    if (gnt) begin
      m_pend[gidx]--;
      m_out   = ~m_out;
      m_gid   = gidx;
      m_rr    = (gidx + 1) % N_REQ;
      next_ok = cyc + MIN_GAP + 1;
      m_tog++;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (r[i] != m_prev[i]) begin
        if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
        else                   m_pend[i]++;
      end
    end
    m_prev = r;
    cyc++;
    pend_any = 0;
    for (int i = 0; i < N_REQ; i++) if (m_pend[i] != 0) pend_any = 1;
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'((cyc < next_ok) || pend_any));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (out !== obs_out_prev) begin
      dut_tog++;
      tog_cyc.push_back(cyc);
      tog_gid.push_back(int'(grant_id));
    end
    obs_out_prev = out;
  endtask

  task automatic pulse(input logic [N_REQ-1:0] mask);
    cur = cur ^ mask;
    step(cur);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(cur);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    dut_tog = 0; m_tog = 0;
    tog_cyc.delete(); tog_gid.delete();
  endtask

  initial begin
    cyc = 0; m_tog = 0; dut_tog = 0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // single pulse on req[0]: toggle one edge later, busy gone after the gap
    pulse(2'b01);
    chk("t1_no_early_out", 32'(out), 32'd0);
    step(cur);
    chk("t1_out_rise", 32'(out), 32'd1);
    chk("t1_gid", 32'(grant_id), 32'd0);
    idle(2);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // simultaneous arrivals: grants 3 cycles apart, exactly two toggles
    do_reset();
    pulse(2'b11);
    idle(8);
    chk("t2_toggles", 32'(dut_tog), 32'd2);
    if (tog_cyc.size() == 2) begin
      chk("t2_gap", 32'(tog_cyc[1] - tog_cyc[0]), 32'(MIN_GAP + 1));
      chk("t2_gid0", 32'(tog_gid[0]), 32'd0);
      chk("t2_gid1", 32'(tog_gid[1]), 32'd1);
    end else begin
      chk("t2_toggle_list", 32'(tog_cyc.size()), 32'd2);
    end

    // 8 consecutive pulses on req[1]: drain keeps up
    do_reset();
    repeat (8) pulse(2'b10);
    idle(30);
    chk("t3a_overflow", 32'(overflow), 32'd0);
    chk("t3a_toggles", 32'(dut_tog), 32'd8);

    // 11 pulses: counter reaches full exactly on a grant edge, nothing dropped
    do_reset();
    repeat (11) pulse(2'b10);
    idle(30);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_toggles", 32'(dut_tog), 32'd11);

    // 12 pulses: one dropped, overflow[1] sticky
    do_reset();
    repeat (12) pulse(2'b10);
    idle(40);
    chk("t3b_overflow", 32'(overflow), 32'b10);
    chk("t3b_toggles", 32'(dut_tog), 32'(m_tog));
    chk("t3b_dropped", 32'(dut_tog), 32'd11);

    // both pending for 10 grants: alternation and 3-cycle spacing
    do_reset();
    repeat (5) pulse(2'b11);
    idle(40);
    chk("t4_toggles", 32'(dut_tog), 32'd10);
    for (int i = 0; i < tog_gid.size(); i++) begin
      chk("t4_rotation", 32'(tog_gid[i]), 32'(i % 2));
      if (i > 0) chk("t4_spacing", 32'(tog_cyc[i] - tog_cyc[i-1]), 32'(MIN_GAP + 1));
    end

    // reset in GAP with 3 pending: everything discarded
    do_reset();
    pulse(2'b11);
    pulse(2'b01);
    pulse(2'b10);
    chk("t6_busy_before", 32'(busy), 32'd1);
    do_reset();
    idle(12);
    chk("t6_no_toggle", 32'(dut_tog), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    pulse(2'b01);
    idle(4);
    chk("t6_new_req", 32'(dut_tog), 32'd1);

    // random toggling with occasional asynchronous resets
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [N_REQ-1:0] mask;
      mask = N_REQ'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) mask = '0;
      pulse(mask);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    idle(60);
    chk("rand_toggles", 32'(dut_tog), 32'(m_tog));
    chk("rand_drained", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
